// File: rtl/mandelbrot_pixel_packer.sv
// Paces the mandelbrot engine, packs two 4-bit pixels per byte, streams via FIFO.
// Optional in-set pixel counter: define MANDEL_PIX_STATS_EN.
module mandelbrot_pixel_packer #(
  parameter int FIFO_DEPTH = 4
`ifdef MANDEL_PIX_STATS_EN
  , parameter int STAT_WIDTH = 17
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       frame_done,
  output logic       eng_run,
  input  logic       eng_running,
  input  logic       eng_finished,
  input  logic [3:0] eng_ctr,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_first,
  output logic       m_last
`ifdef MANDEL_PIX_STATS_EN
  , output logic [STAT_WIDTH-1:0] stat_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT_RUN, WAIT_DONE
  } state_t;

  state_t state, state_nx;

  logic          running_d;
  logic          done_pix;
  logic          cap;
  logic          push;
  logic          pop;
  logic          start_acc;
  logic          half;
  logic          first_pend;
  logic [3:0]    held;
  logic [9:0]    push_word;
  logic [9:0]    rd_word;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  assign done_pix  = running_d & ~eng_running;
  assign cap       = (state == WAIT_DONE) & done_pix;
  assign push      = cap & (half | eng_finished);
  assign pop       = m_valid & m_ready;
  assign start_acc = (state == IDLE) & start;
  assign busy      = (state != IDLE);

  assign push_word = {half ? {eng_ctr, held} : {4'h0, eng_ctr},
                      first_pend, eng_finished};

  // Outputs gated so an empty FIFO presents all zeros
  assign m_valid = (count != '0);
  assign rd_word = m_valid ? mem[rd_ptr] : '0;
  assign m_data  = rd_word[9:2];
  assign m_first = rd_word[1];
  assign m_last  = rd_word[0];

  always_comb begin
    state_nx = state;
    eng_run  = 1'b0;
    unique case (state)
      IDLE: if (start) state_nx = ISSUE;
      ISSUE: begin
        eng_run = (count < FULL);
        if (eng_run) state_nx = WAIT_RUN;
      end
      WAIT_RUN: if (eng_running) state_nx = WAIT_DONE;
      WAIT_DONE: begin
        if (done_pix) state_nx = eng_finished ? IDLE : ISSUE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      running_d  <= 1'b0;
      half       <= 1'b0;
      held       <= 4'h0;
      first_pend <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      running_d  <= eng_running;
      frame_done <= cap & eng_finished;
      if (start_acc)
        first_pend <= 1'b1;
      else if (push)
        first_pend <= 1'b0;
      if (cap) begin
        if (half) begin
          half <= 1'b0;
        end else if (!eng_finished) begin
          half <= 1'b1;
          held <= eng_ctr;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; reads are masked by m_valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

`ifdef MANDEL_PIX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stat_count <= '0;
    else if (start_acc)
      stat_count <= '0;
    else if (cap && eng_ctr == 4'hF && stat_count != '1)
      stat_count <= stat_count + 1'b1;
  end
`endif

endmodule
